// File: rtl/ceas_timekeeper_if.sv
// ceas_timekeeper_if
// Groups the user buttons and the time-of-day outputs of the timekeeper.
//
// Signals:
//   btn_mode  debounced mode button level (driven by master)
//   btn_inc   debounced increment button level (driven by master)
//   ore       hours 0..23, registered
//   minute    minutes 0..59, registered
//   secunde   seconds 0..59, registered
//   sec_tick  one-cycle pulse in the cycle a new seconds value first appears
//   mode      current setting mode: 00 RUN, 01 SET_ORE, 10 SET_MIN
//
// Handshake: sec_tick is a valid-only strobe qualifying a fresh time value.
// There is no ready; the consumer cannot stall the clock, so it must accept
// the time fields in the cycle sec_tick is high or simply read them later.
// The time fields are always valid as levels regardless of sec_tick.
//
// Modports:
//   master  the button source / display consumer
//   slave   the timekeeper itself
interface ceas_timekeeper_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] ore;
    logic [5:0] minute;
    logic [5:0] secunde;
    logic       sec_tick;
    logic [1:0] mode;

    modport master (
        output btn_mode, btn_inc,
        input  ore, minute, secunde, sec_tick, mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output ore, minute, secunde, sec_tick, mode
    );
endinterface

// File: rtl/ceas_timekeeper.sv
// ceas_timekeeper
// Time-of-day counter for the four-digit display. Divides the system clock
// to 1 Hz, keeps seconds/minutes/hours and wraps at 23:59:59. A mode button
// cycles RUN -> SET_ORE -> SET_MIN -> RUN; an increment button advances the
// field currently being set.
//
// Ports:
//   clock  system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    ceas_timekeeper_if.slave: buttons in; ore/minute/secunde,
//          sec_tick and mode out (all registered)
module ceas_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input logic               clock,
    input logic               reset,
    ceas_timekeeper_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    // Encodings double as the externally visible mode code.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_ORE = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    ore_q, ore_d;
    logic          tick_q, tick_d;
    logic          mode_prev_q, inc_prev_q;
    logic          mode_press, inc_press;

    // Rising-edge detect: acted on at the same edge the high level is sampled,
    // so a held button yields a single event.
    assign mode_press = bus.btn_mode & ~mode_prev_q;
    assign inc_press  = bus.btn_inc  & ~inc_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            ore_q       <= '0;
            tick_q      <= 1'b0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            ore_q       <= ore_d;
            tick_q      <= tick_d;
            mode_prev_q <= bus.btn_mode;
            inc_prev_q  <= bus.btn_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ore_d   = ore_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d = ST_SET_ORE;
                end
                // Time keeps running on the edge that leaves RUN; freezing
                // starts from the following cycle.
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            ore_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_SET_ORE: begin
                // Mode has priority; a coincident inc press is dropped.
                if (mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (inc_press) begin
                    ore_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
                end
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    // Restart the second cleanly so the first tick lands a
                    // full second after returning to RUN.
                    state_d = ST_RUN;
                    sec_d   = '0;
                    presc_d = '0;
                end else if (inc_press) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.ore      = ore_q;
    assign bus.minute   = min_q;
    assign bus.secunde  = sec_q;
    assign bus.sec_tick = tick_q;
    assign bus.mode     = state_q;

endmodule

// File: tb/tb_ceas_timekeeper.sv
// tb_ceas_timekeeper
// Directed bench for ceas_timekeeper with TICKS_PER_SEC = 4. The driver
// pushes expected snapshots and expected sec_tick events into queues; a
// monitor on the falling edge pops and compares them.
module tb_ceas_timekeeper;

    localparam int TPS       = 4;
    localparam int CLK_HALF  = 5;
    localparam int MAX_CYC   = 20000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #CLK_HALF clock = ~clock;

    ceas_timekeeper_if tk_if ();

    ceas_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tk_if.slave)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Snapshot: {ore[4:0], minute[5:0], secunde[5:0], mode[1:0], sec_tick}
    logic [19:0] exp_q[$];
    string       name_q[$];
    // Tick: {cycle[31:0], ore[4:0], minute[5:0], secunde[5:0]}
    logic [48:0] tick_q[$];

    logic sample_req = 1'b0;
    logic drain_req  = 1'b0;
    logic drain_done = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [19:0] act_v;
        logic [19:0] exp_v;
        logic [48:0] te;
        string       nm;
        act_v = {tk_if.ore, tk_if.minute, tk_if.secunde, tk_if.mode, tk_if.sec_tick};

        if (sample_req && exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got ore=%0d min=%0d sec=%0d mode=%0d tick=%0d, need ore=%0d min=%0d sec=%0d mode=%0d tick=%0d",
                         nm, act_v[19:15], act_v[14:9], act_v[8:3], act_v[2:1], act_v[0],
                         exp_v[19:15], exp_v[14:9], exp_v[8:3], exp_v[2:1], exp_v[0]);
            end
        end

        if (tk_if.sec_tick === 1'b1) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick at cycle %0d: got %0d:%0d:%0d, need no tick",
                         cyc, tk_if.ore, tk_if.minute, tk_if.secunde);
            end else begin
                te = tick_q.pop_front();
                if ({32'(cyc), tk_if.ore, tk_if.minute, tk_if.secunde} !== te) begin
                    errors++;
                    $display("FAIL tick: got cycle %0d time %0d:%0d:%0d, need cycle %0d time %0d:%0d:%0d",
                             cyc, tk_if.ore, tk_if.minute, tk_if.secunde,
                             te[48:17], te[16:12], te[11:6], te[5:0]);
                end
            end
        end else if (tick_q.size() != 0 && int'(tick_q[0][48:17]) < cyc) begin
            te = tick_q.pop_front();
            checks++;
            errors++;
            $display("FAIL tick_missing: got no tick by cycle %0d, need tick at cycle %0d time %0d:%0d:%0d",
                     cyc, te[48:17], te[16:12], te[11:6], te[5:0]);
        end

        if (drain_req && !drain_done) begin
            checks++;
            if (exp_q.size() != 0 || tick_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d snapshots and %0d ticks pending, need 0 and 0",
                         exp_q.size(), tick_q.size());
            end
            drain_done = 1'b1;
        end

        if (cyc > MAX_CYC) begin
            $display("FAIL watchdog: got cycle %0d, need finish before %0d", cyc, MAX_CYC);
            $fatal(1, "watchdog expired");
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_snap(input string nm, input int o, input int m,
                               input int s, input int md, input int tk);
        exp_q.push_back({5'(o), 6'(m), 6'(s), 2'(md), 1'(tk)});
        name_q.push_back(nm);
        sample_req = 1'b1;
        @(negedge clock);
        #1;
        sample_req = 1'b0;
    endtask

    // Expected ticks: one per second after cycle 'base', starting from o:m:s.
    task automatic push_ticks(input int base, input int n, input int o,
                              input int m, input int s);
        int ho;
        int mi;
        int se;
        ho = o;
        mi = m;
        se = s;
        for (int k = 1; k <= n; k++) begin
            se++;
            if (se == 60) begin
                se = 0;
                mi++;
                if (mi == 60) begin
                    mi = 0;
                    ho++;
                    if (ho == 24) ho = 0;
                end
            end
            tick_q.push_back({32'(base + TPS * k), 5'(ho), 6'(mi), 6'(se)});
        end
    endtask

    task automatic press_inc();
        tk_if.btn_inc = 1'b1;
        step(1);
        tk_if.btn_inc = 1'b0;
        step(1);
    endtask

    // c_after: cycle count right after the edge that acts on the press.
    task automatic press_mode(output int c_after);
        tk_if.btn_mode = 1'b1;
        step(1);
        c_after = cyc;
        tk_if.btn_mode = 1'b0;
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        tk_if.btn_mode = 1'b1;   // held through reset, released with it
        tk_if.btn_inc  = 1'b0;
        reset          = 1'b1;
        step(3);
        reset          = 1'b0;
        tk_if.btn_mode = 1'b0;
        expect_snap("reset_state", 0, 0, 0, 0, 0);

        // One minute of running: 60 ticks, 4 cycles apart.
        c = cyc;
        push_ticks(c, 60, 0, 0, 0);
        step(60 * TPS);
        expect_snap("run_one_minute", 0, 1, 0, 0, 1);

        // Set 23:59 then run up to 23:59:58 and across midnight.
        press_mode(c);
        repeat (23) press_inc();
        expect_snap("set_ore_23", 23, 1, 0, 1, 0);
        press_mode(c);
        repeat (58) press_inc();
        expect_snap("set_min_59", 23, 59, 0, 2, 0);
        press_mode(c);
        push_ticks(c, 60, 23, 59, 0);
        step(58 * TPS - 1);
        expect_snap("run_23_59_58", 23, 59, 58, 0, 1);
        step(2 * TPS);
        expect_snap("midnight_wrap", 0, 0, 0, 0, 1);

        // Run 7 s, then exercise SET_ORE wrap with seconds frozen at 7.
        c = cyc;
        push_ticks(c, 7, 0, 0, 0);
        step(7 * TPS);
        press_mode(c);
        repeat (22) press_inc();
        expect_snap("ore_22", 22, 0, 7, 1, 0);
        press_inc();
        expect_snap("ore_23", 23, 0, 7, 1, 0);
        press_inc();
        expect_snap("ore_wrap_0", 0, 0, 7, 1, 0);
        press_inc();
        expect_snap("ore_1", 1, 0, 7, 1, 0);
        step(20);
        expect_snap("set_frozen", 1, 0, 7, 1, 0);

        // Mode and inc together: mode wins.
        tk_if.btn_mode = 1'b1;
        tk_if.btn_inc  = 1'b1;
        step(1);
        expect_snap("mode_beats_inc", 1, 0, 7, 2, 0);
        tk_if.btn_mode = 1'b0;
        tk_if.btn_inc  = 1'b0;
        step(1);

        // Held inc gives one event; then minute wrap in SET_MIN.
        tk_if.btn_inc = 1'b1;
        step(20);
        tk_if.btn_inc = 1'b0;
        step(1);
        expect_snap("held_inc_once", 1, 1, 7, 2, 0);
        repeat (58) press_inc();
        expect_snap("min_59", 1, 59, 7, 2, 0);
        press_inc();
        expect_snap("min_wrap_0", 1, 0, 7, 2, 0);

        // Back to RUN: seconds cleared, first tick exactly TPS cycles later.
        press_mode(c);
        push_ticks(c, 1, 1, 0, 0);
        expect_snap("run_resume", 1, 0, 0, 0, 0);
        step(TPS - 1);
        expect_snap("first_tick_after_set", 1, 0, 1, 0, 1);

        // Reset in the middle of SET_MIN with buttons held.
        press_mode(c);
        press_mode(c);
        repeat (37) press_inc();
        expect_snap("min_37", 1, 37, 1, 2, 0);
        tk_if.btn_mode = 1'b1;
        tk_if.btn_inc  = 1'b1;
        reset          = 1'b1;
        step(1);
        expect_snap("reset_mid_set", 0, 0, 0, 0, 0);
        step(1);
        reset          = 1'b0;
        tk_if.btn_mode = 1'b0;
        tk_if.btn_inc  = 1'b0;
        c = cyc;
        push_ticks(c, 3, 0, 0, 0);
        step(3 * TPS);
        expect_snap("after_reset_run", 0, 0, 3, 0, 1);

        drain_req = 1'b1;
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
